// File: rtl/flog_iter_stream.sv
// Streaming log2 of an EXP/MAN float using bit-serial iterative squaring.
// One operation in flight; valid/ready handshake on both sides.
module flog_iter_stream #(
    parameter int EXP       = 8,
    parameter int MAN       = 7,
    parameter int FRAC_BITS = 12,
    parameter int GUARD     = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sign,
    input  logic [EXP-1:0] exponent,
    input  logic [MAN-1:0] fractional,
    input  logic           input_valid,
    output logic           ready_o,
    output logic           s_res_o,
    output logic [EXP-1:0] e_res_o,
    output logic [MAN-1:0] f_res_o,
    output logic           valid_o,
    input  logic           ready_i
);

    localparam int W    = MAN + 1 + GUARD;
    localparam int BIAS = (1 << (EXP - 1)) - 1;
    localparam int RW   = EXP + 1 + FRAC_BITS;
    localparam int CW   = $clog2(FRAC_BITS + 1);
    localparam int LW   = $clog2(RW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [W-1:0]         m_q, m_d;
    logic [EXP:0]         exp_q, exp_d;
    logic [FRAC_BITS-1:0] frac_acc_q, frac_acc_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;
    logic                 s_res_q, s_res_d;
    logic [EXP-1:0]       e_res_q, e_res_d;
    logic [MAN-1:0]       f_res_q, f_res_d;

    logic                 accept_s;
    logic                 special_s;
    logic                 spec_s_s;
    logic [EXP-1:0]       spec_e_s;
    logic [MAN-1:0]       spec_f_s;
    logic [2*W-1:0]       sq_s;
    logic                 bit_s;
    logic [RW-1:0]        r_s;
    logic [RW-1:0]        mag_s;
    logic [LW-1:0]        lead_s;
    logic [RW-1:0]        norm_sh_s;
    logic [EXP-1:0]       e_norm_s;
    logic [MAN-1:0]       f_norm_s;
    logic                 unused_bits_s;

    assign accept_s = input_valid & ready_q & (state_q == IDLE);

    // Classify the operand into the IEEE special results.
    always_comb begin
        special_s = 1'b1;
        spec_s_s  = 1'b0;
        spec_e_s  = {EXP{1'b1}};
        spec_f_s  = {1'b1, {(MAN-1){1'b0}}};
        if (exponent == {EXP{1'b0}}) begin
            spec_s_s = 1'b1;
            spec_f_s = {MAN{1'b0}};
        end else if (&exponent) begin
            if ((fractional == {MAN{1'b0}}) && !sign) begin
                spec_f_s = {MAN{1'b0}};
            end else begin
                spec_f_s = {1'b1, {(MAN-1){1'b0}}};
            end
        end else if (sign) begin
            spec_f_s = {1'b1, {(MAN-1){1'b0}}};
        end else begin
            special_s = 1'b0;
        end
    end

    // One squaring step: an overflow past 2.0 yields a 1 bit and a halved mantissa.
    always_comb begin
        sq_s  = (2*W)'(m_q) * (2*W)'(m_q);
        bit_s = sq_s[2*W-1];
    end

    // Combine integer exponent and fraction bits, then find the leading one.
    always_comb begin
        r_s    = {exp_q, frac_acc_q};
        mag_s  = r_s[RW-1] ? (~r_s + RW'(1)) : r_s;
        lead_s = {LW{1'b0}};
        for (int i = 0; i < RW; i++) begin
            lead_s = mag_s[i] ? LW'(i) : lead_s;
        end
        norm_sh_s = mag_s << (LW'(RW - 1) - lead_s);
        f_norm_s  = norm_sh_s[RW-2 -: MAN];
        e_norm_s  = EXP'(BIAS - FRAC_BITS) + EXP'(lead_s);
    end

    assign unused_bits_s = &{1'b0, sq_s[W-2:0], norm_sh_s[RW-1], norm_sh_s[RW-MAN-2:0]};

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            m_q        <= {W{1'b0}};
            exp_q      <= {(EXP+1){1'b0}};
            frac_acc_q <= {FRAC_BITS{1'b0}};
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            s_res_q    <= 1'b0;
            e_res_q    <= {EXP{1'b0}};
            f_res_q    <= {MAN{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_q        <= m_d;
            exp_q      <= exp_d;
            frac_acc_q <= frac_acc_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            s_res_q    <= s_res_d;
            e_res_q    <= e_res_d;
            f_res_q    <= f_res_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = special_s ? DONE : ITER;
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                if (cnt_q == CW'(FRAC_BITS - 1)) begin
                    state_d = NORM;
                end else begin
                    state_d = ITER;
                end
            end
            NORM: state_d = DONE;
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        cnt_d      = cnt_q;
        m_d        = m_q;
        exp_d      = exp_q;
        frac_acc_d = frac_acc_q;
        ready_d    = ready_q;
        valid_d    = valid_q;
        s_res_d    = s_res_q;
        e_res_d    = e_res_q;
        f_res_d    = f_res_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    ready_d = 1'b0;
                    if (special_s) begin
                        valid_d = 1'b1;
                        s_res_d = spec_s_s;
                        e_res_d = spec_e_s;
                        f_res_d = spec_f_s;
                    end else begin
                        exp_d      = {1'b0, exponent} - (EXP+1)'(BIAS);
                        m_d        = {1'b1, fractional, {GUARD{1'b0}}};
                        cnt_d      = {CW{1'b0}};
                        frac_acc_d = {FRAC_BITS{1'b0}};
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            ITER: begin
                cnt_d      = cnt_q + CW'(1);
                frac_acc_d = {frac_acc_q[FRAC_BITS-2:0], bit_s};
                m_d        = bit_s ? sq_s[2*W-1 -: W] : sq_s[2*W-2 -: W];
            end
            NORM: begin
                valid_d = 1'b1;
                if (mag_s == {RW{1'b0}}) begin
                    s_res_d = 1'b0;
                    e_res_d = {EXP{1'b0}};
                    f_res_d = {MAN{1'b0}};
                end else begin
                    s_res_d = r_s[RW-1];
                    e_res_d = e_norm_s;
                    f_res_d = f_norm_s;
                end
            end
            DONE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign s_res_o = s_res_q;
    assign e_res_o = e_res_q;
    assign f_res_o = f_res_q;

endmodule
